// File: rtl/spi_burst_master.sv
// SPI master for the LCD path: a small TX FIFO of {last,dc,data} words feeds a shifter
// with runtime divider, CPOL/CPHA and bit order. CS stays low until a word tagged last completes.
module spi_burst_master #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 8
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [DIV_W-1:0]                   cfg_div,
  input  logic                               cfg_cpol,
  input  logic                               cfg_cpha,
  input  logic                               cfg_lsb_first,
  input  logic                               tx_valid,
  output logic                               tx_ready,
  input  logic [DATA_W-1:0]                  tx_data,
  input  logic                               tx_dc,
  input  logic                               tx_last,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               busy,
  output logic                               done,
  output logic                               spi_clk,
  output logic                               spi_mosi,
  output logic                               spi_cs_n,
  output logic                               lcd_dc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int EW = DATA_W + 2;
  localparam int BW = $clog2(DATA_W+1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEAD    = 3'd1,
    ST_TRAIL   = 3'd2,
    ST_STALL   = 3'd3,
    ST_CS_HOLD = 3'd4
  } state_t;

  logic [EW-1:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q;

  state_t            state_q;
  logic [DIV_W-1:0]  cnt_q;
  logic [BW-1:0]     bit_q;
  logic [DATA_W-1:0] shift_q;
  logic              last_q;
  logic              cs_n_q, sclk_q, mosi_q, dc_q, busy_q, done_q;
  logic [DIV_W-1:0]  div_q;
  logic              cpol_q, cpha_q, lsb_q;

  logic              push, pop, fifo_empty;
  logic [EW-1:0]     head;
  logic              use_cfg, eff_cpha, eff_lsb;
  logic [DIV_W-1:0]  eff_div;

  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  assign fifo_empty = (level_q == '0);
  assign tx_ready   = (level_q != LW'(FIFO_DEPTH));
  assign push       = tx_valid && tx_ready;
  assign head       = mem_q[rd_ptr_q];

  // The head word is popped from IDLE/STALL, or at the final trailing edge of a non-last word
  // so consecutive words stream with no gap.
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty) begin
      case (state_q)
        ST_IDLE, ST_STALL: pop = 1'b1;
        ST_TRAIL:          pop = (cnt_q == '0) && (bit_q == BW'(1)) && !last_q;
        default:           pop = 1'b0;
      endcase
    end
  end

  assign use_cfg  = (state_q == ST_IDLE);
  assign eff_cpha = use_cfg ? cfg_cpha      : cpha_q;
  assign eff_lsb  = use_cfg ? cfg_lsb_first : lsb_q;
  assign eff_div  = use_cfg ? cfg_div       : div_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {tx_last, tx_dc, tx_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      last_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      dc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div_q   <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          sclk_q <= cfg_cpol;
          if (pop) begin
            div_q  <= cfg_div;
            cpol_q <= cfg_cpol;
            cpha_q <= cfg_cpha;
            lsb_q  <= cfg_lsb_first;
          end
        end
        ST_LEAD: begin
          if (cnt_q == '0) begin
            sclk_q  <= ~cpol_q;
            cnt_q   <= div_q;
            state_q <= ST_TRAIL;
            if (cpha_q) begin
              mosi_q  <= first_bit(shift_q, lsb_q);
              shift_q <= advance(shift_q, lsb_q);
            end
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end
        ST_TRAIL: begin
          if (cnt_q == '0) begin
            sclk_q <= cpol_q;
            if (bit_q != BW'(1)) begin
              bit_q   <= bit_q - BW'(1);
              cnt_q   <= div_q;
              state_q <= ST_LEAD;
              if (!cpha_q) begin
                mosi_q  <= first_bit(shift_q, lsb_q);
                shift_q <= advance(shift_q, lsb_q);
              end
            end else if (last_q) begin
              cnt_q   <= div_q;
              state_q <= ST_CS_HOLD;
            end else if (fifo_empty) begin
              state_q <= ST_STALL;
            end
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end
        ST_STALL: begin
          sclk_q <= cpol_q;
        end
        ST_CS_HOLD: begin
          if (cnt_q == '0) begin
            cs_n_q  <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Word load overrides the per-state updates above.
      if (pop) begin
        cnt_q   <= eff_div;
        bit_q   <= BW'(DATA_W);
        dc_q    <= head[EW-2];
        last_q  <= head[EW-1];
        cs_n_q  <= 1'b0;
        busy_q  <= 1'b1;
        state_q <= ST_LEAD;
        if (eff_cpha) begin
          shift_q <= head[DATA_W-1:0];
        end else begin
          mosi_q  <= first_bit(head[DATA_W-1:0], eff_lsb);
          shift_q <= advance(head[DATA_W-1:0], eff_lsb);
        end
      end
    end
  end

  assign fifo_level = level_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign spi_clk    = sclk_q;
  assign spi_mosi   = mosi_q;
  assign spi_cs_n   = cs_n_q;
  assign lcd_dc     = dc_q;

endmodule

// File: tb/tb_spi_burst_master.sv
// Directed bench for spi_burst_master: a monitor captures MOSI on every spi_clk rise
// while CS is low, and the directed tests compare against hand-computed values.
module tb_spi_burst_master;

  localparam int DW  = 8;
  localparam int FD  = 8;
  localparam int DVW = 8;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [DVW-1:0]  cfg_div = 8'd1;
  logic            cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_lsb_first = 1'b0;
  logic            tx_valid = 1'b0;
  logic            tx_ready;
  logic [DW-1:0]   tx_data = '0;
  logic            tx_dc = 1'b0, tx_last = 1'b0;
  logic [$clog2(FD+1)-1:0] fifo_level;
  logic            busy, done, spi_clk, spi_mosi, spi_cs_n, lcd_dc;

  spi_burst_master #(.DATA_W(DW), .FIFO_DEPTH(FD), .DIV_W(DVW)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_div(cfg_div), .cfg_cpol(cfg_cpol),
    .cfg_cpha(cfg_cpha), .cfg_lsb_first(cfg_lsb_first), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_dc(tx_dc), .tx_last(tx_last),
    .fifo_level(fifo_level), .busy(busy), .done(done), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n), .lcd_dc(lcd_dc)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Monitor: written only here, read by the stimulus process.
  int   cyc, done_cnt, cs_rise_cnt, cs_fall_cyc;
  logic prev_sclk, prev_cs;
  bit   bits_q[$];
  bit   dcs_q[$];
  int   rise_q[$];

  initial begin
    cyc = 0; done_cnt = 0; cs_rise_cnt = 0; cs_fall_cyc = 0;
    prev_sclk = 1'b0; prev_cs = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!spi_cs_n && spi_clk && !prev_sclk) begin
        bits_q.push_back(spi_mosi);
        dcs_q.push_back(lcd_dc);
        rise_q.push_back(cyc);
      end
      if (done) done_cnt++;
      if (spi_cs_n && !prev_cs) cs_rise_cnt++;
      if (!spi_cs_n && prev_cs) cs_fall_cyc = cyc;
      prev_sclk = spi_clk;
      prev_cs   = spi_cs_n;
    end
  end

  function automatic logic [31:0] get_bits(input int base, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[30:0], bits_q[base+i]};
    return v;
  endfunction

  function automatic int bad_intervals(input int base, input int n, input int exp);
    int bad = 0;
    for (int i = 0; i < n-1; i++)
      if (rise_q[base+i+1] - rise_q[base+i] != exp) bad++;
    return bad;
  endfunction

  task automatic push(input logic [7:0] d, input logic dc, input logic last);
    int w = 0;
    @(negedge clk);
    tx_valid = 1'b1; tx_data = d; tx_dc = dc; tx_last = last;
    while (!tx_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 2000) check("push_timeout", 32'(w), 0);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int base = done_cnt;
    int w = 0;
    while (done_cnt == base && w < budget) begin
      @(negedge clk);
      w++;
    end
    check(tag, 32'(done_cnt != base), 1);
  endtask

  task automatic wait_bits(input string tag, input int target, input int budget);
    int w = 0;
    while (bits_q.size() < target && w < budget) begin
      @(negedge clk);
      w++;
    end
    check(tag, 32'(bits_q.size() >= target), 1);
  endtask

  int b, b2, d0, cr0, bad;

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_sclk", spi_clk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_dc", lcd_dc, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_level", fifo_level, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: mode 0, div=1, single 0xA5 word
    b = bits_q.size(); d0 = done_cnt;
    push(8'hA5, 1'b1, 1'b1);
    check("t1_level_after_push", fifo_level, 1);
    check("t1_cs_still_high", spi_cs_n, 1);
    @(posedge clk); #1;
    check("t1_cs_low_T1", spi_cs_n, 0);
    check("t1_busy", busy, 1);
    wait_done("t1_done_seen", 300);
    repeat (5) @(negedge clk);
    check("t1_nbits", 32'(bits_q.size() - b), 8);
    check("t1_bits", get_bits(b, 8), 32'hA5);
    check("t1_dc", dcs_q[b], 1);
    check("t1_intervals", 32'(bad_intervals(b, 8, 4)), 0);
    check("t1_first_rise", 32'(rise_q[b] - cs_fall_cyc), 2);
    check("t1_done_count", 32'(done_cnt - d0), 1);
    check("t1_cs_end", spi_cs_n, 1);
    check("t1_busy_end", busy, 0);
    $display("test1 mode0 0xA5 complete");

    // 2: mode 3, LSB first, 0x81 then 0x3C
    @(negedge clk);
    cfg_cpol = 1'b1; cfg_cpha = 1'b1; cfg_lsb_first = 1'b1;
    repeat (2) @(negedge clk);
    check("t2_idle_sclk", spi_clk, 1);
    b = bits_q.size(); d0 = done_cnt; cr0 = cs_rise_cnt;
    push(8'h81, 1'b0, 1'b0);
    push(8'h3C, 1'b0, 1'b1);
    wait_done("t2_done_seen", 400);
    repeat (5) @(negedge clk);
    check("t2_nbits", 32'(bits_q.size() - b), 16);
    check("t2_bits", get_bits(b, 16), 32'h813C);
    check("t2_cs_rises", 32'(cs_rise_cnt - cr0), 1);
    check("t2_done_count", 32'(done_cnt - d0), 1);
    check("t2_idle_sclk_end", spi_clk, 1);
    $display("test2 mode3 lsb-first burst complete");

    // 3: overfill the FIFO while busy
    @(negedge clk);
    cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_lsb_first = 1'b0; cfg_div = 8'd0;
    repeat (2) @(negedge clk);
    b = bits_q.size(); d0 = done_cnt;
    push(8'hC0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    for (int i = 1; i <= 8; i++) push(8'hC0 + 8'(i), 1'b0, 1'b0);
    @(negedge clk);
    check("t3_full_ready", tx_ready, 0);
    check("t3_full_level", fifo_level, 8);
    push(8'hC9, 1'b0, 1'b1);
    wait_done("t3_done_seen", 1500);
    repeat (5) @(negedge clk);
    check("t3_nbits", 32'(bits_q.size() - b), 80);
    for (int i = 0; i < 10; i++) check($sformatf("t3_word%0d", i), get_bits(b + 8*i, 8), 32'hC0 + 32'(i));
    check("t3_done_count", 32'(done_cnt - d0), 1);
    $display("test3 fifo full burst complete");

    // 4: stall between words
    @(negedge clk);
    cfg_div = 8'd1;
    b = bits_q.size(); d0 = done_cnt;
    push(8'h12, 1'b0, 1'b0);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (spi_cs_n || !busy) bad++;
    end
    check("t4_gap_bad_cycles", 32'(bad), 0);
    check("t4_gap_cs", spi_cs_n, 0);
    check("t4_gap_sclk", spi_clk, 0);
    check("t4_gap_busy", busy, 1);
    push(8'h34, 1'b0, 1'b1);
    wait_done("t4_done_seen", 300);
    repeat (5) @(negedge clk);
    check("t4_bits", get_bits(b, 16), 32'h1234);
    check("t4_done_count", 32'(done_cnt - d0), 1);
    $display("test4 stall gap complete");

    // 5: reset mid-bit 4
    b = bits_q.size();
    push(8'hF0, 1'b1, 1'b0);
    push(8'h0F, 1'b0, 1'b0);
    push(8'hAA, 1'b0, 1'b1);
    wait_bits("t5_reach_bit4", b + 4, 300);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("t5_rst_cs", spi_cs_n, 1);
    check("t5_rst_sclk", spi_clk, 0);
    check("t5_rst_level", fifo_level, 0);
    check("t5_rst_busy", busy, 0);
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (60) @(negedge clk);
    check("t5_no_done", 32'(done_cnt - d0), 0);
    check("t5_cs_idle", spi_cs_n, 1);
    $display("test5 reset abort complete");

    // 6: divider change mid-burst only affects the next burst
    b = bits_q.size(); d0 = done_cnt;
    push(8'h55, 1'b0, 1'b0);
    push(8'h66, 1'b0, 1'b1);
    wait_bits("t6_reach_bit3", b + 3, 200);
    @(negedge clk);
    cfg_div = 8'd7;
    wait_done("t6_done1_seen", 600);
    repeat (5) @(negedge clk);
    check("t6_nbits1", 32'(bits_q.size() - b), 16);
    check("t6_bits1", get_bits(b, 16), 32'h5566);
    check("t6_intervals1", 32'(bad_intervals(b, 16, 4)), 0);
    b2 = bits_q.size();
    push(8'h77, 1'b0, 1'b1);
    wait_done("t6_done2_seen", 800);
    repeat (5) @(negedge clk);
    check("t6_nbits2", 32'(bits_q.size() - b2), 8);
    check("t6_bits2", get_bits(b2, 8), 32'h77);
    check("t6_intervals2", 32'(bad_intervals(b2, 8, 16)), 0);
    check("t6_first_rise2", 32'(rise_q[b2] - cs_fall_cyc), 8);
    check("t6_done_count", 32'(done_cnt - d0), 2);
    $display("test6 divider change complete");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
